inst_fetch_sequencer: RTL and testbench

INST_FETCH_SEQUENCER -- requirements
Module: inst_fetch_sequencer

---
 rtl/inst_fetch_sequencer.sv | 73 +++++++
 tb/tb_inst_fetch_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_sequencer.sv
// rtl/inst_fetch_sequencer.sv - byte-serial instruction fetch and assembly FSM
module inst_fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t      state;
   logic [1:0]  cnt;
   logic [31:0] pc;

   // Request is gated by rst so memory sees no access while reset is held.
   assign mem_req  = (state == FETCH) && !rst;
   assign mem_addr = {pc[31:2], cnt};

   // Fetch FSM: redirect overrides both byte collection and the HOLD handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FETCH;
         cnt        <= 2'd0;
         pc         <= RESET_PC_ALIGNED;
         inst       <= 32'd0;
         inst_pc    <= RESET_PC_ALIGNED;
         inst_valid <= 1'b0;
      end else if (redirect_valid) begin
         state      <= FETCH;
         cnt        <= 2'd0;
         pc         <= {redirect_pc[31:2], 2'b00};
         inst_valid <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (mem_req && mem_ack) begin
                  inst[{cnt, 3'b000} +: 8] <= mem_rdata;
                  cnt <= cnt + 2'd1;
                  if (cnt == 2'd3) begin
                     state      <= HOLD;
                     inst_valid <= 1'b1;
                     inst_pc    <= pc;
                  end
               end
            end
            HOLD: begin
               if (inst_ready) begin
                  pc         <= pc + 32'd4;
                  inst_valid <= 1'b0;
                  state      <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_sequencer.sv
// tb/tb_inst_fetch_sequencer.sv - randomized self-checking bench for inst_fetch_sequencer
module tb_inst_fetch_sequencer;

   logic        clk;
   logic        rst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;

   int n_checks;
   int n_errors;

   // reference model: address of current instruction, bytes received, holding flag
   logic [31:0] m_pc;
   int          m_n;
   bit          m_hold;

   inst_fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'd0:   mem_byte = 8'h13;
         32'd1:   mem_byte = 8'h05;
         32'd2:   mem_byte = 8'h10;
         32'd3:   mem_byte = 8'h00;
         default: mem_byte = a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
      endcase
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] p);
      mem_word = {mem_byte(p + 32'd3), mem_byte(p + 32'd2), mem_byte(p + 32'd1), mem_byte(p)};
   endfunction

   assign mem_rdata = mem_ack ? mem_byte(mem_addr) : 8'hEE;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // one clock: drive inputs, check outputs against the model mid-cycle, advance model at the edge
   task automatic cycle(input logic r, input logic ack, input logic rv,
                        input logic [31:0] rp, input logic rd);
      rst            = r;
      mem_ack        = ack;
      redirect_valid = rv;
      redirect_pc    = rp;
      inst_ready     = rd;
      @(negedge clk);
      chk("mem_req", {31'd0, mem_req}, {31'd0, !m_hold && !r});
      chk("mem_addr", mem_addr, m_pc + 32'(m_n));
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_hold});
      if (m_hold) begin
         chk("inst", inst, mem_word(m_pc));
         chk("inst_pc", inst_pc, m_pc);
      end
      @(posedge clk);
      if (r) begin
         m_pc = 32'd0; m_n = 0; m_hold = 0;
      end else if (rv) begin
         m_pc = rp & 32'hFFFF_FFFC; m_n = 0; m_hold = 0;
      end else if (!m_hold && ack) begin
         m_n++;
         if (m_n == 4) begin
            m_n = 0; m_hold = 1;
         end
      end else if (m_hold && rd) begin
         m_hold = 0; m_pc = m_pc + 32'd4;
      end
      #1;
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      m_pc = 32'd0; m_n = 0; m_hold = 0;
      rst = 1'b1; mem_ack = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b0;
      @(posedge clk); #1;
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      cycle(1, 1, 0, 0, 0);

      // basic fetch, 5-cycle latency, stall in HOLD
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
      chk("lat_not_yet", {31'd0, inst_valid}, 32'd0);
      cycle(0, 1, 0, 0, 0);
      chk("lat_valid", {31'd0, inst_valid}, 32'd1);
      chk("first_inst", inst, 32'h0010_0513);
      chk("first_pc", inst_pc, 32'd0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
      chk("held_inst", inst, 32'h0010_0513);
      cycle(0, 1, 0, 0, 1);
      chk("next_addr4", mem_addr, 32'd4);

      // ack stall while cnt==2
      cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      chk("stall_addr", mem_addr, 32'd6);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      chk("stall_inst", inst, mem_word(32'd4));
      cycle(0, 1, 0, 0, 1);

      // redirect mid-fetch with an ack discarded
      cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 1, 32'h0000_0103, 0);
      chk("redir_addr", mem_addr, 32'h100);
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
      chk("redir_inst", inst, mem_word(32'h100));
      chk("redir_pc", inst_pc, 32'h100);

      // redirect together with a HOLD handshake
      cycle(0, 1, 1, 32'h40, 1);
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
      chk("hs_pc40", inst_pc, 32'h40);
      cycle(0, 1, 1, 32'h80, 1);
      chk("hs_redir_addr", mem_addr, 32'h80);

      // pc wrap, then reset mid-fetch
      cycle(0, 1, 1, 32'hFFFF_FFFE, 0);
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
      chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
      cycle(0, 1, 0, 0, 1);
      chk("wrap_addr", mem_addr, 32'd0);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      cycle(1, 1, 0, 0, 0);
      chk("rst_mid_addr", mem_addr, 32'd0);
      chk("rst_mid_valid", {31'd0, inst_valid}, 32'd0);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         cycle(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 19) == 0),
               $urandom(),
               $urandom_range(0, 1) == 1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
